filter_sample_ctrl: RTL
=======================

Name: filter_sample_ctrl

Overview:
- Sample-side controller that drives the adaptive filter's trigger interface and consumes its result.
- Accepts one-cycle sample strobes from the converter front end and presents the sample to the filter, holding it stable for the filter's whole computation.
- Pulses sample_trig, waits for filter_done, captures the filter result and hands it downstream over valid/ready.
- Counts dropped input samples and overwritten output results, and flags a filter timeout.

Parameters:
DATA_SIZE, 24, sample width in bits (two's complement), matching the filter datapath.
GUARD, 3, cycles spent in HOLD after capture, so the filter is back in IDLE before the next trigger.
TIMEOUT, 16, maximum cycles in WAIT for filter_done before flagging an error.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
in_valid  in  1  one-cycle strobe: in_data holds a new sample; no backpressure.
in_data  in  DATA_SIZE  input sample.
filt_data_in  out  DATA_SIZE  sample presented to the filter; registered.
sample_trig  out  1  registered one-cycle start pulse to the filter.
filter_done  in  1  from filter; the filter result is valid on filt_data_out in the following cycle.
filt_data_out  in  DATA_SIZE  filter result.
out_valid  out  1  out_data holds an unconsumed result.
out_ready  in  1  downstream accepts when out_valid and out_ready are both high.
out_data  out  DATA_SIZE  captured filter result.
busy  out  1  high whenever state is not IDLE.
err_timeout  out  1  sticky timeout flag.
clear_err  in  1  synchronous clear of err_timeout and both counters.
overrun_cnt  out  CNT_W  count of input samples dropped because the block was busy; saturating.
drop_cnt  out  CNT_W  count of results overwritten before downstream consumed them; saturating.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Reset asserted mid-operation aborts immediately; the in-flight sample and result are lost.
- FSM states: IDLE, TRIG, WAIT, CAPT, HOLD.
  - IDLE: on in_valid, register filt_data_in <= in_data and go to TRIG.
  - TRIG: sample_trig=1 for exactly this one cycle; load the timeout counter with TIMEOUT; go to WAIT.
  - WAIT: if filter_done, go to CAPT. Otherwise decrement the timeout counter; on reaching 0, set err_timeout and go to IDLE with no output.
  - CAPT: out_data <= filt_data_out; out_valid <= 1; load the guard counter with GUARD; go to HOLD.
  - HOLD: decrement the guard counter; go to IDLE after GUARD cycles.
- Timing: in_valid at cycle k gives sample_trig at k+1, filter_done expected at k+2, and out_valid high from k+4.
- With GUARD=3 the block returns to IDLE at k+7, so minimum accepted sample spacing is 7 cycles.
- filt_data_in changes only on acceptance in IDLE. It is therefore stable from the trigger until the filter finishes.
- in_valid in any state other than IDLE: sample dropped, overrun_cnt increments.
- Output handshake: out_valid clears on the out_valid and out_ready handshake.
- CAPT while out_valid=1 and no handshake that cycle: out_data is overwritten, out_valid stays 1, drop_cnt increments.
- CAPT coinciding with a handshake: the old result counts as consumed, the new result is loaded, drop_cnt is unchanged.
- filter_done outside WAIT: ignored.
- Counters saturate at 2^CNT_W-1.
- clear_err has priority over an increment in the same cycle. It does not affect the FSM or the data path.
- err_timeout does not block operation; the next in_valid is processed normally.

Test Plan:
- Single sample: in_data=24'h123456 pulse, filter model asserts done 1 cycle after trig and returns 24'hABCDEF -> filt_data_in=24'h123456 stable from k+1 to k+6; sample_trig high only at k+1; out_data=24'hABCDEF with out_valid at k+4; busy low at k+7.
- Overrun: second in_valid at k+3 -> sample ignored, filt_data_in unchanged, overrun_cnt=1. Next in_valid at k+7 -> accepted normally.
- Backpressure: out_ready=0 across two processed samples (results 24'h000001, 24'h000002) -> out_data=24'h000002, drop_cnt=1. Then out_ready=1 -> out_valid drops the next cycle.
- Timeout: filter never asserts done -> err_timeout=1 after 16 WAIT cycles, out_valid stays 0, busy low. Then clear_err -> err_timeout=0 and counters 0.
- Async reset in WAIT -> all outputs 0 immediately without a clock edge. After release, a new sample processes with 7-cycle timing.
- Negative boundary: in_data=24'h800000, filter returns 24'h7FFFFF -> passed bit-exact with no sign alteration. Back-to-back samples every 7 cycles for 100 samples -> overrun_cnt=0.

Source files
------------

// File: rtl/filter_sample_ctrl.sv
// filter_sample_ctrl
//   Sample-side controller for the adaptive filter. It accepts one-cycle
//   sample strobes, presents the sample to the filter, and holds it stable
//   for the whole computation. It pulses sample_trig, waits for filter_done,
//   captures the filter result and offers it downstream over valid/ready.
//   It also keeps saturating counts of dropped samples and overwritten
//   results, and raises a sticky flag when the filter times out.
//
// Ports
//   clk, reset        : clock; asynchronous active-high reset
//   in_valid, in_data : sample strobe and sample (no backpressure)
//   filt_data_in      : registered sample presented to the filter
//   sample_trig       : registered one-cycle start pulse to the filter
//   filter_done       : filter finished; result valid on filt_data_out next cycle
//   filt_data_out     : filter result
//   out_valid/ready   : downstream handshake for out_data
//   out_data          : captured filter result
//   busy              : FSM not in IDLE
//   err_timeout       : sticky filter-timeout flag
//   clear_err         : synchronous clear of err_timeout and both counters
//   overrun_cnt       : samples dropped while busy (saturating)
//   drop_cnt          : results overwritten before consumption (saturating)
module filter_sample_ctrl #(
  parameter int unsigned DATA_SIZE = 24,
  parameter int unsigned GUARD     = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic [DATA_SIZE-1:0] filt_data_in,
  output logic                 sample_trig,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] filt_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 err_timeout,
  input  logic                 clear_err,
  output logic [CNT_W-1:0]     overrun_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned GRD_W = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    CAPT,
    HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] filt_data_in_q, filt_data_in_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic                 sample_trig_q, sample_trig_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [GRD_W-1:0]     grd_q, grd_d;
  logic [CNT_W-1:0]     overrun_cnt_q, overrun_cnt_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic handshake;
  logic overrun_evt;
  logic drop_evt;

  always_comb begin
    state_d        = state_q;
    filt_data_in_d = filt_data_in_q;
    out_data_d     = out_data_q;
    sample_trig_d  = 1'b0;
    out_valid_d    = out_valid_q;
    err_timeout_d  = err_timeout_q;
    tmo_d          = tmo_q;
    grd_d          = grd_q;
    overrun_cnt_d  = overrun_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    drop_evt       = 1'b0;

    handshake   = out_valid_q & out_ready;
    overrun_evt = in_valid & (state_q != IDLE);

    if (handshake) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          filt_data_in_d = in_data;
          sample_trig_d  = 1'b1;
          state_d        = TRIG;
        end
      end
      TRIG: begin
        tmo_d   = TMO_W'(TIMEOUT);
        state_d = WAIT;
      end
      WAIT: begin
        if (filter_done) begin
          state_d = CAPT;
        end else if (tmo_q <= TMO_W'(1)) begin
          tmo_d         = '0;
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      CAPT: begin
        // A result still pending without a handshake this cycle is lost;
        // a simultaneous handshake means the old result was consumed.
        out_data_d  = filt_data_out;
        out_valid_d = 1'b1;
        drop_evt    = out_valid_q & ~handshake;
        grd_d       = GRD_W'(GUARD);
        state_d     = HOLD;
      end
      HOLD: begin
        if (grd_q <= GRD_W'(1)) begin
          grd_d   = '0;
          state_d = IDLE;
        end else begin
          grd_d = grd_q - GRD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wins over a same-cycle increment or timeout.
    if (clear_err) begin
      err_timeout_d = 1'b0;
      overrun_cnt_d = '0;
      drop_cnt_d    = '0;
    end else begin
      if (overrun_evt && (overrun_cnt_q != '1)) begin
        overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
      end
      if (drop_evt && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      filt_data_in_q <= '0;
      out_data_q     <= '0;
      sample_trig_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      tmo_q          <= '0;
      grd_q          <= '0;
      overrun_cnt_q  <= '0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      filt_data_in_q <= filt_data_in_d;
      out_data_q     <= out_data_d;
      sample_trig_q  <= sample_trig_d;
      out_valid_q    <= out_valid_d;
      err_timeout_q  <= err_timeout_d;
      tmo_q          <= tmo_d;
      grd_q          <= grd_d;
      overrun_cnt_q  <= overrun_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign filt_data_in = filt_data_in_q;
  assign sample_trig  = sample_trig_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = (state_q != IDLE);
  assign err_timeout  = err_timeout_q;
  assign overrun_cnt  = overrun_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
